// File: rtl/fetch_unit.sv
// fetch_unit: picoMIPS instruction fetch stage.
// Owns the program counter, issues the program-memory address and latches
// the returned word into the instruction register for decode.
module fetch_unit #(
   parameter int unsigned      Psize   = 6,
   parameter int unsigned      Isize   = 20,
   parameter logic [Isize-1:0] HALT_OP = 20'hFFFFF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [Psize-1:0] branch_off,
   input  logic             jump,
   input  logic [Psize-1:0] jump_addr,
   output logic [Psize-1:0] imem_addr,
   input  logic [Isize-1:0] imem_data,
   output logic [Isize-1:0] instr,
   output logic [Psize-1:0] instr_pc,
   output logic             instr_valid,
   output logic             halted
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t           state, state_n;
   logic [Psize-1:0] pc, pc_n;
   logic [Isize-1:0] instr_n;
   logic [Psize-1:0] instr_pc_n;
   logic             instr_valid_n;
   logic             halt_hit;
   logic             redir;
   logic [Psize-1:0] target;

   assign halted = (state == HALT);

   // Next-state, redirect qualification and fetch-address selection.
   // A HALT_OP in the instruction register overrides any redirect asserted
   // alongside it, so the address stays at pc and the jump never reaches memory.
   always_comb begin
      state_n       = state;
      pc_n          = pc;
      instr_n       = instr;
      instr_pc_n    = instr_pc;
      instr_valid_n = instr_valid;

      halt_hit  = (state == RUN) && instr_valid && !stall && (instr == HALT_OP);
      redir     = (state == RUN) && instr_valid && !stall && (jump || branch_taken) && !halt_hit;
      target    = jump ? jump_addr : instr_pc + branch_off;
      imem_addr = redir ? target : pc;

      case (state)
         BOOT: begin
            instr_n       = imem_data;
            instr_pc_n    = '0;
            instr_valid_n = 1'b1;
            pc_n          = Psize'(1);
            state_n       = RUN;
         end
         RUN: begin
            if (halt_hit) begin
               instr_valid_n = 1'b0;
               state_n       = HALT;
            end else if (!stall) begin
               instr_n       = imem_data;
               instr_pc_n    = imem_addr;
               instr_valid_n = 1'b1;
               pc_n          = imem_addr + 1'b1;
            end
         end
         default: begin
            state_n = HALT;
         end
      endcase
   end

   // State and instruction-register update with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= BOOT;
         pc          <= '0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         instr       <= instr_n;
         instr_pc    <= instr_pc_n;
         instr_valid <= instr_valid_n;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized checks of fetch_unit against a
// behavioural model of the fetch stage.
module tb_fetch_unit;

   localparam int PS = 6;
   localparam int IS = 20;
   localparam logic [IS-1:0] HOP = 20'hFFFFF;

   logic          clk;
   logic          reset, stall, branch_taken, jump;
   logic [PS-1:0] branch_off, jump_addr, imem_addr, instr_pc;
   logic [IS-1:0] imem_data, instr;
   logic          instr_valid, halted;

   logic [IS-1:0] mem [64];

   int tests = 0;
   int fails = 0;

   // model state
   bit            m_boot, m_halt, m_valid;
   int            m_pc, m_ipc;
   logic [IS-1:0] m_instr;
   int            addr_seen;

   fetch_unit #(.Psize(PS), .Isize(IS), .HALT_OP(HOP)) dut (
      .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
      .branch_off(branch_off), .jump(jump), .jump_addr(jump_addr),
      .imem_addr(imem_addr), .imem_data(imem_data), .instr(instr),
      .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted)
   );

   assign imem_data = mem[imem_addr];

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Address the fetch stage should present this cycle, from the model.
   function automatic int model_addr();
      bit go;
      go = !m_boot && !m_halt && m_valid && !stall && (jump || branch_taken) && (m_instr != HOP);
      if (!go) return m_pc;
      if (jump) return int'(jump_addr);
      return (m_ipc + int'(branch_off)) % 64;
   endfunction

   task automatic model_edge(input int a);
      if (reset) begin
         m_boot = 1; m_halt = 0; m_valid = 0; m_pc = 0; m_ipc = 0; m_instr = '0;
      end else if (m_boot) begin
         m_boot = 0; m_instr = mem[0]; m_ipc = 0; m_valid = 1; m_pc = 1;
      end else if (m_halt) begin
         // frozen until reset
      end else if (m_valid && m_instr == HOP && !stall) begin
         m_halt = 1; m_valid = 0;
      end else if (!stall) begin
         m_instr = mem[a]; m_ipc = a; m_valid = 1; m_pc = (a + 1) % 64;
      end
   endtask

   // One clock cycle: drive inputs, check address, clock, check registers.
   task automatic step(input bit r, input bit s, input bit b, input int off,
                       input bit j, input int ja);
      int a;
      reset = r; stall = s; branch_taken = b; branch_off = PS'(off);
      jump = j; jump_addr = PS'(ja);
      #2;
      a = model_addr();
      addr_seen = int'(imem_addr);
      if (!r) check("imem_addr", imem_addr, a);
      @(posedge clk);
      #1;
      model_edge(a);
      check("instr", instr, m_instr);
      check("instr_pc", instr_pc, m_ipc);
      check("instr_valid", instr_valid, m_valid);
      check("halted", halted, m_halt);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int k = 0; k < 64; k++) mem[k] = IS'(k);
      reset = 1; stall = 0; branch_taken = 0; branch_off = '0; jump = 0; jump_addr = '0;
      #1;
      @(posedge clk);
      #1;
      model_edge(0);
      check("rst_instr", instr, 0);
      check("rst_pc", instr_pc, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_halted", halted, 0);

      // boot and sequential run with wrap
      step(0, 0, 0, 0, 0, 0);
      check("boot_pc", instr_pc, 0);
      check("boot_valid", instr_valid, 1);
      for (int k = 1; k < 64; k++) begin
         step(0, 0, 0, 0, 0, 0);
         check("seq_pc", instr_pc, k);
         check("seq_instr", instr, k);
      end
      step(0, 0, 0, 0, 0, 0);
      check("wrap_pc", instr_pc, 0);

      // relative branch backwards
      run(10);
      check("pre_br_pc", instr_pc, 10);
      step(0, 0, 1, 'h3C, 0, 0);
      check("br_addr", addr_seen, 6);
      check("br_pc", instr_pc, 6);
      check("br_instr", instr, 6);
      step(0, 0, 0, 0, 0, 0);
      check("br_next", instr_pc, 7);
      check("br_valid", instr_valid, 1);

      // jump wins over branch; branch wrap
      step(0, 0, 0, 0, 1, 5);
      step(0, 0, 1, 9, 1, 40);
      check("jmp_pri", instr_pc, 40);
      step(0, 0, 0, 0, 1, 62);
      step(0, 0, 1, 3, 0, 0);
      check("br_wrap", instr_pc, 1);

      // stall holds and ignores the branch until released
      step(0, 0, 0, 0, 1, 20);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, 5, 0, 0);
         check("stall_pc", instr_pc, 20);
         check("stall_valid", instr_valid, 1);
      end
      step(0, 0, 1, 5, 0, 0);
      check("stall_rel", instr_pc, 25);

      // halt at address 4
      mem[4] = HOP;
      step(0, 0, 0, 0, 1, 2);
      run(2);
      check("pre_halt", instr_pc, 4);
      step(0, 0, 0, 0, 0, 0);
      check("halt_flag", halted, 1);
      check("halt_valid", instr_valid, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 1, 30);
         check("halt_addr", addr_seen, 5);
      end

      // reset from halt, then reset mid-stall
      step(1, 0, 0, 0, 1, 30);
      check("rh_halted", halted, 0);
      check("rh_valid", instr_valid, 0);
      step(0, 0, 0, 0, 0, 0);
      check("rh_boot", instr_pc, 0);
      run(2);
      step(0, 1, 1, 7, 0, 0);
      step(1, 1, 1, 7, 0, 0);
      check("rs_pc", instr_pc, 0);
      check("rs_valid", instr_valid, 0);
      step(0, 1, 1, 7, 0, 0);
      check("rs_boot", instr_pc, 0);
      check("rs_bvalid", instr_valid, 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit r;
         r = ($urandom_range(0, 99) == 0);
         if (r) begin
            for (int k = 0; k < 64; k++)
               mem[k] = ($urandom_range(0, 15) == 0) ? HOP : IS'($urandom_range(0, 20'hFFFFE));
         end
         step(r, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              int'($urandom_range(0, 63)), $urandom_range(0, 5) == 0,
              int'($urandom_range(0, 63)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
